// File: rtl/emmc_xfer_seq.sv
// eMMC post-init data-transfer sequencer: turns block read/write requests into
// CMD23/17/18/24/25/12 sequences, kicks the data host and reports a result code.
module emmc_xfer_seq #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned BLK_CNT_W   = 16,
  parameter bit          USE_CMD23   = 1'b1,
  parameter int unsigned MAX_RETRY   = 2,
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter logic [31:0] R1_ERR_MASK = 32'hFFF8_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    blk_addr_i,
  input  logic [BLK_CNT_W-1:0] blk_cnt_i,
  output logic                 ready_o,
  output logic                 done_o,
  output logic [2:0]           err_code_o,
  output logic [31:0]          card_status_o,
  output logic                 cmd_start_o,
  output logic [5:0]           cmd_idx_o,
  output logic [31:0]          cmd_arg_o,
  input  logic                 cmd_done_i,
  input  logic                 cmd_err_i,
  input  logic [31:0]          cmd_resp_i,
  output logic                 dat_read_o,
  output logic                 dat_write_o,
  output logic [BLK_CNT_W-1:0] dat_blk_cnt_o,
  input  logic                 dat_done_i,
  input  logic                 dat_crc_ok_i,
  input  logic                 busy_i
);
  localparam int unsigned TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  localparam logic [2:0] E_OK = 3'd0, E_CMD = 3'd1, E_R1 = 3'd2, E_CRC = 3'd3,
                         E_DTMO = 3'd4, E_BUSY = 3'd5;

  typedef enum logic [2:0] {
    IDLE, SET_CNT, ISSUE, WAIT_RESP, WAIT_DAT, STOP, WAIT_BUSY, FINISH
  } state_e;
  typedef enum logic [1:0] {PH_CNT, PH_DATA, PH_STOP} phase_e;

  state_e               state_q;
  phase_e               phase_q;
  logic                 we_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [RTY_W-1:0]     retry_q;
  logic [TMO_W-1:0]     tmo_q;
  logic                 ready_q, done_q, cmd_start_q, dat_read_q, dat_write_q;
  logic [2:0]           err_q;
  logic [31:0]          status_q, cmd_arg_q;
  logic [5:0]           cmd_idx_q, data_idx_d;
  logic [BLK_CNT_W-1:0] cnt_q;
  logic                 multi_d, open_d, tmo_hit_d;

  function automatic logic [5:0] data_idx(input logic we, input logic multi);
    return we ? (multi ? 6'd25 : 6'd24) : (multi ? 6'd18 : 6'd17);
  endfunction

  // The first error of a request wins; later failures (e.g. CMD12) never overwrite it.
  function automatic logic [2:0] keep_first(input logic [2:0] cur, input logic [2:0] code);
    return (cur != E_OK) ? cur : code;
  endfunction

  function automatic state_e phase_state(input phase_e ph);
    case (ph)
      PH_CNT:  return SET_CNT;
      PH_DATA: return ISSUE;
      default: return STOP;
    endcase
  endfunction

  assign multi_d    = (cnt_q != BLK_CNT_W'(1));
  assign open_d     = !USE_CMD23 && multi_d;
  assign data_idx_d = data_idx(we_q, multi_d);
  assign tmo_hit_d  = (tmo_q == TMO_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      phase_q     <= PH_CNT;
      we_q        <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      retry_q     <= '0;
      tmo_q       <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= E_OK;
      status_q    <= '0;
      cmd_start_q <= 1'b0;
      cmd_idx_q   <= '0;
      cmd_arg_q   <= '0;
      dat_read_q  <= 1'b0;
      dat_write_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      cmd_start_q <= 1'b0;
      dat_read_q  <= 1'b0;
      dat_write_q <= 1'b0;
      tmo_q       <= tmo_q + TMO_W'(1);
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (start_i && blk_cnt_i != '0) begin
            ready_q     <= 1'b0;
            err_q       <= E_OK;
            retry_q     <= '0;
            we_q        <= we_i;
            addr_q      <= blk_addr_i;
            cnt_q       <= blk_cnt_i;
            cmd_start_q <= 1'b1;
            if (USE_CMD23 && blk_cnt_i != BLK_CNT_W'(1)) begin
              phase_q   <= PH_CNT;
              state_q   <= SET_CNT;
              cmd_idx_q <= 6'd23;
              cmd_arg_q <= 32'(blk_cnt_i);
            end else begin
              // Read kick rides with the command so the host catches early data.
              phase_q    <= PH_DATA;
              state_q    <= ISSUE;
              cmd_idx_q  <= data_idx(we_i, blk_cnt_i != BLK_CNT_W'(1));
              cmd_arg_q  <= 32'(blk_addr_i);
              dat_read_q <= !we_i;
            end
          end
        end
        SET_CNT, ISSUE, STOP: begin
          tmo_q   <= '0;
          state_q <= WAIT_RESP;
        end
        WAIT_RESP: begin
          if (cmd_err_i || (!cmd_done_i && tmo_hit_d)) begin
            tmo_q <= '0;
            if (retry_q != RTY_MAX) begin
              retry_q     <= retry_q + RTY_W'(1);
              cmd_start_q <= 1'b1;
              dat_read_q  <= (phase_q == PH_DATA) && !we_q;
              state_q     <= phase_state(phase_q);
            end else begin
              err_q   <= keep_first(err_q, E_CMD);
              done_q  <= 1'b1;
              state_q <= FINISH;
            end
          end else if (cmd_done_i) begin
            tmo_q    <= '0;
            status_q <= cmd_resp_i;
            if ((cmd_resp_i & R1_ERR_MASK) != '0) begin
              err_q   <= keep_first(err_q, E_R1);
              done_q  <= 1'b1;
              state_q <= FINISH;
            end else begin
              case (phase_q)
                PH_CNT: begin
                  phase_q     <= PH_DATA;
                  state_q     <= ISSUE;
                  cmd_start_q <= 1'b1;
                  cmd_idx_q   <= data_idx_d;
                  cmd_arg_q   <= 32'(addr_q);
                  dat_read_q  <= !we_q;
                end
                PH_DATA: begin
                  dat_write_q <= we_q;
                  state_q     <= WAIT_DAT;
                end
                default: state_q <= WAIT_BUSY;
              endcase
            end
          end
        end
        WAIT_DAT: begin
          if (dat_done_i || tmo_hit_d) begin
            tmo_q <= '0;
            if (!dat_done_i)        err_q <= keep_first(err_q, E_DTMO);
            else if (!dat_crc_ok_i) err_q <= keep_first(err_q, E_CRC);
            if (open_d) begin
              phase_q     <= PH_STOP;
              state_q     <= STOP;
              cmd_start_q <= 1'b1;
              cmd_idx_q   <= 6'd12;
              cmd_arg_q   <= '0;
            end else if (!dat_done_i || !dat_crc_ok_i || !we_q) begin
              done_q  <= 1'b1;
              state_q <= FINISH;
            end else begin
              state_q <= WAIT_BUSY;
            end
          end
        end
        WAIT_BUSY: begin
          // tmo_q != 0 enforces a minimum of two cycles before busy_i is trusted.
          if (!busy_i && tmo_q != '0) begin
            done_q  <= 1'b1;
            state_q <= FINISH;
          end else if (tmo_hit_d) begin
            err_q   <= keep_first(err_q, E_BUSY);
            done_q  <= 1'b1;
            state_q <= FINISH;
          end
        end
        FINISH: begin
          tmo_q   <= '0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o       = ready_q;
  assign done_o        = done_q;
  assign err_code_o    = err_q;
  assign card_status_o = status_q;
  assign cmd_start_o   = cmd_start_q;
  assign cmd_idx_o     = cmd_idx_q;
  assign cmd_arg_o     = cmd_arg_q;
  assign dat_read_o    = dat_read_q;
  assign dat_write_o   = dat_write_q;
  assign dat_blk_cnt_o = cnt_q;

endmodule

// File: doc/emmc_xfer_seq.md
Name: emmc_xfer_seq

Overview:
Parametrised eMMC data-transfer sequencer; the post-init successor to the fixed eMMC state machine.
- Takes block-addressed read/write requests with arbitrary block count.
- Drives the command host (start/index/argument) and data host (read/write kick, block count), optionally using CMD23 pre-defined block count instead of CMD12.
- Checks R1 status, retries failed commands, applies per-phase timeouts, and reports a completion/error code.
- Sits between the user request port and sd_cmd_host / sd_data_8bit_host, after card initialisation has completed.

Parameters:
ADDR_W, 32, block address width (≤32, zero-extended into the argument)
BLK_CNT_W, 16, block count width (≤16)
USE_CMD23, 1, 1: multi-block uses CMD23+CMD18/25 with no CMD12; 0: open-ended CMD18/25 terminated by CMD12
MAX_RETRY, 2, extra attempts after a failed command phase
TIMEOUT_CYC, 65535, per-phase timeout in clk_i cycles
R1_ERR_MASK, 32'hFFF8_0000, response bits treated as errors

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
start_i  in  1  request strobe, accepted only when ready_o=1
we_i  in  1  1=write, 0=read; sampled with start_i
blk_addr_i  in  ADDR_W  start block address; sampled with start_i
blk_cnt_i  in  BLK_CNT_W  block count; sampled with start_i
ready_o  out  1  idle, request accepted
done_o  out  1  one-cycle completion pulse
err_code_o  out  3  result; valid from done_o until next accept
card_status_o  out  32  last R1 response
cmd_start_o  out  1  one-cycle command start pulse
cmd_idx_o  out  6  command index; held while waiting for the response
cmd_arg_o  out  32  command argument; held while waiting for the response
cmd_done_i  in  1  response received pulse
cmd_err_i  in  1  command CRC/timeout/index error pulse
cmd_resp_i  in  32  response word 0; valid with cmd_done_i
dat_read_o  out  1  data host read kick pulse
dat_write_o  out  1  data host write kick pulse
dat_blk_cnt_o  out  BLK_CNT_W  block count to the data host; held for the whole transfer
dat_done_i  in  1  data phase finished pulse
dat_crc_ok_i  in  1  data CRC status; valid with dat_done_i
busy_i  in  1  card DAT0 busy

Behaviour:
- Reset (rst_ni=0 at a clk_i edge) from any state, including mid-transfer:
  - state IDLE; ready_o=1.
  - All pulse outputs 0; err_code_o=0, card_status_o=0, cmd_idx_o/cmd_arg_o=0, dat_blk_cnt_o=0.
  - Retry and timeout counters cleared.
- All outputs are registered. Accept on edge N implies cmd_start_o=1 during cycle N+1.
- Accept: IDLE & start_i & blk_cnt_i≠0.
  - Latch we, addr, cnt; clear err_code_o.
  - start_i with blk_cnt_i=0, or start_i outside IDLE, is ignored (no done_o).
- States: IDLE, SET_CNT, ISSUE, WAIT_RESP, WAIT_DAT, STOP, WAIT_BUSY, FINISH.
- Command selection:
  - cnt=1: CMD17 (read) / CMD24 (write).
  - cnt>1: CMD18 / CMD25.
  - Data-command argument: zero-extended addr.
  - With USE_CMD23 and cnt>1, SET_CNT first issues CMD23, argument {16'b0, cnt}.
- Read data kick: dat_read_o pulses in the same cycle as cmd_start_o of CMD17/18, so the host is armed before early data.
- Write data kick: dat_write_o pulses one cycle after a good cmd_done_i for CMD24/25.
- WAIT_RESP:
  - cmd_err_i, or TIMEOUT_CYC cycles without a response, is a failure. Retry (re-enter SET_CNT/ISSUE) while retries<MAX_RETRY; otherwise FINISH with code 1.
  - cmd_done_i & cmd_err_i in the same cycle counts as an error.
  - Good response: latch card_status_o. Any (resp & R1_ERR_MASK) → FINISH with code 2, no retry.
- WAIT_DAT:
  - dat_done_i & !dat_crc_ok_i → code 3.
  - TIMEOUT_CYC cycles without dat_done_i → code 4.
  - On error, an open-ended multi-block transfer (USE_CMD23=0, cnt>1) still issues CMD12 before FINISH.
- After data, open-ended multi-block goes to STOP (CMD12, argument 0, R1b); otherwise reads go to FINISH and writes to WAIT_BUSY.
- WAIT_BUSY: exits to FINISH when busy_i=0 is sampled, but not earlier than 2 cycles after entry. TIMEOUT_CYC cycles → code 5.
- Code precedence: the first error recorded is kept; a CMD12 failure after a data error does not overwrite it.
- The retry counter resets on each accept and is shared across all command phases of one request.
- FINISH: done_o=1 for one cycle, then IDLE; ready_o=1 on the following cycle.
- err_code_o values: 0 ok, 1 command fail, 2 R1 error, 3 data CRC, 4 data timeout, 5 busy timeout.

Test Plan:
1. Single read: cnt=1, addr=0x1234, responses clean → CMD17 arg 0x00001234 with dat_read_o in the same cycle; dat_done_i/crc_ok → done_o, err_code_o=0, no CMD23/CMD12.
2. Multi-write, USE_CMD23=1: cnt=8, addr=0x40 → CMD23 arg 0x8, CMD25 arg 0x40, dat_write_o 1 cycle after cmd_done_i, dat_blk_cnt_o=8; busy_i high 20 cycles → done_o only after busy_i falls.
3. Multi-read, USE_CMD23=0: cnt=4 → CMD18 then CMD12 after dat_done_i → done_o, code 0.
4. Retry: MAX_RETRY=2, cmd_err_i on the first two CMD17 attempts, clean third → exactly 3 cmd_start_o pulses, code 0. With all three failing → code 1.
5. R1 error: cmd_resp_i=32'h0400_0000 → FINISH code 2, card_status_o=32'h0400_0000, no data kick for writes.
6. Data CRC fail: USE_CMD23=0, cnt=2 read, dat_crc_ok_i=0 → CMD12 still issued, code 3. Separately: rst_ni low mid-WAIT_DAT → next cycle ready_o=1, all pulses 0; start_i with cnt=0 → ignored.
